rx_page_drain: RTL and testbench

RX_PAGE_DRAIN -- requirements
Module: rx_page_drain

---
 rtl/xb_pkg.sv | 23 ++
 rtl/drain_packer.sv | 38 +++
 rtl/rx_page_drain.sv | 187 ++++++++++++++++++
 tb/tb_rx_page_drain.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/xb_pkg.sv
// Shared constants and FSM encoding for the rx page drain datapath.
package xb_pkg;

    localparam int HDATA_WIDTH    = 32;
    localparam int MDATA_WIDTH    = 256;
    localparam int UNIT_BUF_BY_4B = 1024;
    localparam int ADDRESS_WIDTH  = 32;
    localparam int BEATS_PER_PAGE = 128;
    localparam int WORDS_PER_BEAT = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } drain_state_e;

    // Byte stride between consecutive memory beats.
    function automatic int beat_bytes(input int mdata_w);
        return mdata_w / 8;
    endfunction

endpackage

// File: rtl/drain_packer.sv
// Gathers WORDS buffer words into one memory beat; word k lands in lane k (word 0 in the LSBs).
module drain_packer
    import xb_pkg::*;
#(
    parameter int WORD_W = HDATA_WIDTH,
    parameter int WORDS  = WORDS_PER_BEAT
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       clr_i,
    input  logic                       cap_i,
    input  logic [$clog2(WORDS)-1:0]   idx_i,
    input  logic [WORD_W-1:0]          word_i,
    output logic [WORD_W*WORDS-1:0]    data_o
);

    logic [WORD_W*WORDS-1:0] data_q, data_d;

    always_comb begin
        data_d = data_q;
        if (clr_i) begin
            data_d = '0;
        end else if (cap_i) begin
            data_d[int'(idx_i)*WORD_W +: WORD_W] = word_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/rx_page_drain.sv
// Drains one rx buffer page (1024 words) to memory as 128 x 256-bit beats.
// Optional XB_DRAIN_CHECKSUM_EN adds page_checksum, the XOR of all words of the page.
module rx_page_drain
    import xb_pkg::*;
#(
    parameter int HDATA_WIDTH    = xb_pkg::HDATA_WIDTH,
    parameter int MDATA_WIDTH    = xb_pkg::MDATA_WIDTH,
    parameter int UNIT_BUF_BY_4B = xb_pkg::UNIT_BUF_BY_4B,
    parameter int ADDRESS_WIDTH  = xb_pkg::ADDRESS_WIDTH
) (
    input  logic                                 clock_fpga,
    input  logic                                 reset,
    input  logic                                 page_ready,
    input  logic [1:0]                           page_index,
    input  logic [ADDRESS_WIDTH-1:0]             start_address,
    output logic                                 buf_rd_en,
    output logic [$clog2(UNIT_BUF_BY_4B)+1:0]    buf_rd_addr,
    input  logic [HDATA_WIDTH-1:0]               buf_rd_data,
    output logic                                 chip_select,
    output logic                                 write_enable,
    output logic [ADDRESS_WIDTH-1:0]             maddress,
    output logic [MDATA_WIDTH-1:0]               mdata_out,
    input  logic                                 mem_ready,
    output logic                                 xfer_complete,
    output logic                                 busy
`ifdef XB_DRAIN_CHECKSUM_EN
    ,
    output logic [HDATA_WIDTH-1:0]               page_checksum
`endif
);

    localparam int WOFF_W = $clog2(UNIT_BUF_BY_4B);
    localparam int WIDX_W = $clog2(WORDS_PER_BEAT);
    localparam int RDC_W  = WIDX_W + 1;
    localparam int BEAT_W = $clog2(BEATS_PER_PAGE);
    localparam logic [ADDRESS_WIDTH-1:0] BEAT_STEP = ADDRESS_WIDTH'(beat_bytes(MDATA_WIDTH));
    localparam logic [BEAT_W-1:0]        LAST_BEAT = BEAT_W'(BEATS_PER_PAGE - 1);
    localparam logic [WIDX_W-1:0]        LAST_WORD = WIDX_W'(WORDS_PER_BEAT - 1);

    drain_state_e              state_q, state_d;
    logic [1:0]                page_q, page_d;
    logic [ADDRESS_WIDTH-1:0]  addr_q, addr_d;
    logic [WOFF_W-1:0]         woff_q, woff_d;
    logic [RDC_W-1:0]          rd_cnt_q, rd_cnt_d;
    logic [BEAT_W-1:0]         beat_q, beat_d;
    logic                      rd_vld_q;
    logic [WIDX_W-1:0]         rd_idx_q;
    logic                      start;
    logic                      accept;
    logic                      last_cap;

    // Memory handshake: chip_select is the valid, mem_ready the ready; a beat
    // transfers on a cycle where both are 1, and maddress/mdata_out hold until then.
    assign start    = (state_q == ST_IDLE) && page_ready;
    assign accept   = (state_q == ST_WRITE) && mem_ready;
    assign last_cap = rd_vld_q && (rd_idx_q == LAST_WORD);

    always_ff @(posedge clock_fpga or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (page_ready) state_d = ST_FETCH;
            ST_FETCH: if (last_cap)   state_d = ST_WRITE;
            ST_WRITE: if (mem_ready)  state_d = (beat_q == LAST_BEAT) ? ST_DONE : ST_FETCH;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy          = 1'b0;
        buf_rd_en     = 1'b0;
        chip_select   = 1'b0;
        write_enable  = 1'b0;
        xfer_complete = 1'b0;
        unique case (state_q)
            ST_IDLE: ;
            ST_FETCH: begin
                busy      = 1'b1;
                buf_rd_en = ~rd_cnt_q[WIDX_W];
            end
            ST_WRITE: begin
                busy         = 1'b1;
                chip_select  = 1'b1;
                write_enable = 1'b1;
            end
            ST_DONE: begin
                busy          = 1'b1;
                xfer_complete = 1'b1;
            end
            default: ;
        endcase
    end

    // Word offset is its own field so it wraps inside the page and never carries into page_q.
    always_comb begin
        page_d   = page_q;
        addr_d   = addr_q;
        woff_d   = woff_q;
        rd_cnt_d = rd_cnt_q;
        beat_d   = beat_q;
        if (start) begin
            page_d   = page_index;
            addr_d   = start_address;
            woff_d   = '0;
            rd_cnt_d = '0;
            beat_d   = '0;
        end else begin
            if (buf_rd_en) begin
                woff_d   = woff_q + WOFF_W'(1);
                rd_cnt_d = rd_cnt_q + RDC_W'(1);
            end
            if (accept) begin
                addr_d   = addr_q + BEAT_STEP;
                beat_d   = beat_q + BEAT_W'(1);
                rd_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clock_fpga or posedge reset) begin
        if (reset) begin
            page_q   <= '0;
            addr_q   <= '0;
            woff_q   <= '0;
            rd_cnt_q <= '0;
            beat_q   <= '0;
            rd_vld_q <= 1'b0;
            rd_idx_q <= '0;
        end else begin
            page_q   <= page_d;
            addr_q   <= addr_d;
            woff_q   <= woff_d;
            rd_cnt_q <= rd_cnt_d;
            beat_q   <= beat_d;
            rd_vld_q <= buf_rd_en;
            rd_idx_q <= rd_cnt_q[WIDX_W-1:0];
        end
    end

    assign buf_rd_addr = {page_q, woff_q};
    assign maddress    = addr_q;

    drain_packer #(
        .WORD_W (HDATA_WIDTH),
        .WORDS  (WORDS_PER_BEAT)
    ) u_packer (
        .clk_i  (clock_fpga),
        .rst_i  (reset),
        .clr_i  (start),
        .cap_i  (rd_vld_q),
        .idx_i  (rd_idx_q),
        .word_i (buf_rd_data),
        .data_o (mdata_out)
    );

`ifdef XB_DRAIN_CHECKSUM_EN
    logic [HDATA_WIDTH-1:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if (start) begin
            csum_d = '0;
        end else if (rd_vld_q) begin
            csum_d = csum_q ^ buf_rd_data;
        end
    end

    always_ff @(posedge clock_fpga or posedge reset) begin
        if (reset) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign page_checksum = csum_q;
`endif

endmodule

// File: tb/tb_rx_page_drain.sv
// Scoreboard bench for rx_page_drain: directed pages with a buffer model and a memory responder.
module tb_rx_page_drain;

    logic         clock_fpga = 1'b0;
    logic         reset = 1'b1;
    logic         page_ready = 1'b0;
    logic [1:0]   page_index = 2'd0;
    logic [31:0]  start_address = 32'd0;
    logic         buf_rd_en;
    logic [11:0]  buf_rd_addr;
    logic [31:0]  buf_rd_data = 32'd0;
    logic         chip_select;
    logic         write_enable;
    logic [31:0]  maddress;
    logic [255:0] mdata_out;
    logic         mem_ready = 1'b1;
    logic         xfer_complete;
    logic         busy;
`ifdef XB_DRAIN_CHECKSUM_EN
    logic [31:0]  page_checksum;
`endif

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [287:0] exp_q[$];
    int           xfer_q[$];
    logic [287:0] exp_beat;
    int           exp_cyc;
    logic [31:0]  exp_csum = 32'd0;

    logic [31:0]  data_base = 32'd0;
    logic [1:0]   exp_page = 2'd0;
    int           rd_seen = 0;
    int           beats_acc = 0;
    int           stall_beat = -1;
    int           stall_len = 0;
    int           stall_cnt = 0;
    logic         stalling;

    rx_page_drain dut (
        .clock_fpga    (clock_fpga),
        .reset         (reset),
        .page_ready    (page_ready),
        .page_index    (page_index),
        .start_address (start_address),
        .buf_rd_en     (buf_rd_en),
        .buf_rd_addr   (buf_rd_addr),
        .buf_rd_data   (buf_rd_data),
        .chip_select   (chip_select),
        .write_enable  (write_enable),
        .maddress      (maddress),
        .mdata_out     (mdata_out),
        .mem_ready     (mem_ready),
        .xfer_complete (xfer_complete),
        .busy          (busy)
`ifdef XB_DRAIN_CHECKSUM_EN
        ,
        .page_checksum (page_checksum)
`endif
    );

    // Clock and cycle counter
    always #5 clock_fpga = ~clock_fpga;
    always @(posedge clock_fpga) cyc <= cyc + 1;

    // Buffer model: word at offset n of the page holds data_base + n, one cycle after the read
    always @(posedge clock_fpga) begin
        if (buf_rd_en) buf_rd_data <= data_base + {22'd0, buf_rd_addr[9:0]};
    end

    task automatic check(input string name, input logic [287:0] act, input logic [287:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory responder and monitor
    always @(negedge clock_fpga) begin
        if (!reset) begin
            stalling = (stall_cnt > 0 && stall_cnt < stall_len) ||
                       (stall_cnt == 0 && stall_len > 0 && chip_select && beats_acc == stall_beat);
            if (stalling) begin
                mem_ready = 1'b0;
                check("stall_cs", chip_select, 1'b1);
                check("stall_we", write_enable, 1'b1);
                check("stall_no_read", buf_rd_en, 1'b0);
                if (exp_q.size() > 0) check("stall_beat_hold", {maddress, mdata_out}, exp_q[0]);
                stall_cnt++;
            end else begin
                mem_ready = 1'b1;
            end

            if (chip_select) begin
                check("we_in_write", write_enable, 1'b1);
                check("read_in_write", buf_rd_en, 1'b0);
            end else begin
                check("we_outside_write", write_enable, 1'b0);
            end
            if (!busy) check("read_in_idle", buf_rd_en, 1'b0);

            if (buf_rd_en) begin
                check("rd_addr", buf_rd_addr, {exp_page, rd_seen[9:0]});
                rd_seen++;
            end

            if (chip_select && mem_ready) begin
                if (exp_q.size() == 0) begin
                    check("beat_unexpected", 1'b1, 1'b0);
                end else begin
                    exp_beat = exp_q.pop_front();
                    check("beat", {maddress, mdata_out}, exp_beat);
                end
                beats_acc++;
            end

            if (xfer_complete) begin
                if (xfer_q.size() == 0) begin
                    check("xfer_unexpected", 1'b1, 1'b0);
                end else begin
                    exp_cyc = xfer_q.pop_front();
                    check("xfer_cycle", cyc, exp_cyc);
                end
            end
        end
    end

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ctl"}, {buf_rd_en, buf_rd_addr, chip_select, write_enable, xfer_complete, busy}, '0);
        check({tag, "_maddress"}, maddress, '0);
        check({tag, "_mdata"}, mdata_out, '0);
`ifdef XB_DRAIN_CHECKSUM_EN
        check({tag, "_checksum"}, page_checksum, '0);
`endif
    endtask

    // Queue the 128 expected beats and the completion cycle, then raise page_ready for one sample
    task automatic start_page(input logic [1:0] pg, input logic [31:0] sa, input logic [31:0] base,
                              input int sb, input int sl);
        logic [255:0] d;
        @(negedge clock_fpga);
        data_base  = base;
        exp_page   = pg;
        rd_seen    = 0;
        beats_acc  = 0;
        stall_beat = sb;
        stall_len  = sl;
        stall_cnt  = 0;
        exp_csum   = 32'd0;
        for (int n = 0; n < 1024; n++) exp_csum ^= base + 32'(n);
        for (int b = 0; b < 128; b++) begin
            for (int k = 0; k < 8; k++) d[32*k +: 32] = base + 32'(8*b + k);
            exp_q.push_back({sa + 32'(32*b), d});
        end
        xfer_q.push_back(cyc + 1281 + sl);
        page_index    = pg;
        start_address = sa;
        page_ready    = 1'b1;
    endtask

    // Wait (bounded) for completion; optionally disturb the start inputs while busy
    task automatic finish_page(input bit wiggle);
        bit seen = 1'b0;
        for (int i = 0; i < 4000 && !seen; i++) begin
            @(negedge clock_fpga);
            if (xfer_complete) begin
                seen = 1'b1;
                page_ready = 1'b0;
            end else if (wiggle) begin
                page_ready    = i[0];
                page_index    = 2'd3;
                start_address = 32'(i) * 32'h0001_3579;
            end else begin
                page_ready = 1'b0;
            end
        end
        page_ready = 1'b0;
        check("xfer_seen", seen, 1'b1);
`ifdef XB_DRAIN_CHECKSUM_EN
        check("checksum_at_done", page_checksum, exp_csum);
`endif
        @(negedge clock_fpga);
        check("idle_after_done", busy, 1'b0);
        check("reads_per_page", rd_seen, 1024);
        check("beats_left", exp_q.size(), 0);
        check("xfer_left", xfer_q.size(), 0);
`ifdef XB_DRAIN_CHECKSUM_EN
        check("checksum_hold", page_checksum, exp_csum);
`endif
    endtask

    initial begin
        bit hit;
        repeat (3) @(negedge clock_fpga);
        check_outputs_zero("reset");
        reset = 1'b0;
        @(negedge clock_fpga);
        check_outputs_zero("post_reset");

        // First beat {7..0} at 0x1000_0000, first read 2048, completion 1281 cycles after start
        start_page(2'd2, 32'h1000_0000, 32'h0000_0000, -1, 0);
        finish_page(1'b0);

        // Five-cycle memory stall on beat 3 (address 0x1000_0060)
        start_page(2'd0, 32'h1000_0000, 32'h0000_0055, 3, 5);
        finish_page(1'b0);

        // Address wraps from 0xFFFF_FFE0 to 0
        start_page(2'd1, 32'hFFFF_FFE0, 32'h1234_0000, -1, 0);
        finish_page(1'b0);

        // Reset in the middle of beat 50 aborts the page without a release
        start_page(2'd0, 32'h2000_0000, 32'h0000_0100, -1, 0);
        hit = 1'b0;
        for (int i = 0; i < 1000 && !hit; i++) begin
            @(negedge clock_fpga);
            page_ready = 1'b0;
            if (beats_acc == 50) hit = 1'b1;
        end
        check("reach_beat_50", hit, 1'b1);
        repeat (3) @(negedge clock_fpga);
        #1 reset = 1'b1;
        #1 check_outputs_zero("mid_reset");
        exp_q.delete();
        xfer_q.delete();
        @(negedge clock_fpga);
        check_outputs_zero("mid_reset_next");
        repeat (2) @(negedge clock_fpga);
        reset = 1'b0;
        start_page(2'd0, 32'h2000_0000, 32'h0000_0100, -1, 0);
        finish_page(1'b0);

        // Start inputs toggled while busy must not disturb the latched page 1
        start_page(2'd1, 32'h0400_0000, 32'h0000_0203, -1, 0);
        finish_page(1'b1);

`ifdef XB_DRAIN_CHECKSUM_EN
        // Words 0xA5A5_0000 + n fold to a zero checksum
        start_page(2'd3, 32'h0000_0000, 32'hA5A5_0000, -1, 0);
        finish_page(1'b0);
        check("checksum_a5a5", page_checksum, 32'h0000_0000);
`endif

        repeat (3) @(negedge clock_fpga);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
